tt_um_gate_truth_tester: RTL

TT_UM_GATE_TRUTH_TESTER -- requirements
Module: tt_um_gate_truth_tester

---
 rtl/trainer_pkg.sv | 49 ++++
 rtl/sync2.sv | 26 ++
 rtl/tt_um_gate_truth_tester.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/trainer_pkg.sv
// Shared definitions for the gate truth-table tester: gate-select codes,
// FSM state encoding and the expected output of each gate.
package trainer_pkg;

  typedef enum logic [2:0] {
    SEL_AND     = 3'd0,
    SEL_OR      = 3'd1,
    SEL_NOTA    = 3'd2,
    SEL_NAND    = 3'd3,
    SEL_NOR     = 3'd4,
    SEL_XOR     = 3'd5,
    SEL_XNOR    = 3'd6,
    SEL_INVALID = 3'd7
  } gate_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int unsigned CNT_W = 5;
  localparam int unsigned N_W   = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned MAP_W = 4;

  // Down-counter load value: N+2 gives N+3 settle cycles including the zero cycle.
  localparam logic [CNT_W-1:0] SETTLE_EXTRA = 5'd2;

  localparam logic [7:0] UIO_OE_VAL = 8'h0F;

  function automatic logic gate_expect(input gate_sel_e sel, input logic a, input logic b);
    logic y;
    y = 1'b0;
    unique case (sel)
      SEL_AND:  y = a & b;
      SEL_OR:   y = a | b;
      SEL_NOTA: y = ~a;
      SEL_NAND: y = ~(a & b);
      SEL_NOR:  y = ~(a | b);
      SEL_XOR:  y = a ^ b;
      SEL_XNOR: y = ~(a ^ b);
      default:  y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs, cleared by the async reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/tt_um_gate_truth_tester.sv
// Drives the four A/B vectors into an external gate, samples its response
// and reports a per-vector mismatch bitmap with pass/fail.
//
// state  | meaning
// IDLE   | after reset, waiting for a start edge
// SETTLE | A/B driven, waiting N+3 cycles for the gate and synchronizer
// SAMPLE | one cycle: compare synced response against the selected gate
// DONE   | results held until the next start edge
module tt_um_gate_truth_tester
  import trainer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic resp_sync;
  logic start_sync;
  logic start_edge;

  state_e           state_q, state_d;
  gate_sel_e        sel_q, sel_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MAP_W-1:0] bitmap_q, bitmap_d;
  logic             start_prev_q, start_prev_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             unused_ok;

  sync2 u_sync_resp (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ui_in[0]),
    .q     (resp_sync)
  );

  sync2 u_sync_start (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ui_in[4]),
    .q     (start_sync)
  );

  assign start_edge = start_sync & ~start_prev_q;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    n_d          = n_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    bitmap_d     = bitmap_q;
    start_prev_d = start_prev_q;

    if (ena) begin
      start_prev_d = start_sync;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_edge) begin
            sel_d = gate_sel_e'(ui_in[3:1]);
            n_d   = uio_in[7:4];
            idx_d = '0;
            if (sel_d == SEL_INVALID) begin
              state_d  = ST_DONE;
              bitmap_d = 4'hF;
              cnt_d    = '0;
            end else begin
              state_d  = ST_SETTLE;
              bitmap_d = '0;
              cnt_d    = {1'b0, uio_in[7:4]} + SETTLE_EXTRA;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_d = ST_SAMPLE;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        ST_SAMPLE: begin
          if (resp_sync != gate_expect(sel_q, idx_q[0], idx_q[1])) begin
            bitmap_d[idx_q] = 1'b1;
          end
          if (idx_q == 2'd3) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            cnt_d   = {1'b0, n_q} + SETTLE_EXTRA;
            state_d = ST_SETTLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they change with the state flop.
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (bitmap_d == '0);
    fail_d = done_d && (bitmap_d != '0);
    a_d    = busy_d & idx_d[0];
    b_d    = busy_d & idx_d[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= SEL_AND;
      n_q          <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      bitmap_q     <= '0;
      start_prev_q <= 1'b0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      bitmap_q     <= bitmap_d;
      start_prev_q <= start_prev_d;
      a_q          <= a_d;
      b_q          <= b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
    end
  end

  assign uo_out    = {2'b00, fail_q, pass_q, done_q, busy_q, b_q, a_q};
  assign uio_out   = {4'h0, bitmap_q};
  assign uio_oe    = UIO_OE_VAL;
  assign unused_ok = &{1'b0, ui_in[7:5], uio_in[3:0]};

endmodule
